// File: rtl/gate_test_pkg.sv
// Shared types and reference truth tables for the gate test sequencer.
// Truth tables are indexed by input vector: bit k is the expected output for stim == k.
package gate_test_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] TruthNot  = 2'b01;
  localparam logic [3:0] TruthAnd2 = 4'b1000;
  localparam logic [3:0] TruthOr2  = 4'b1110;
  localparam logic [3:0] TruthXor2 = 4'b0110;

endpackage

// File: rtl/hold_timer.sv
// Loadable settle-time counter; tc flags the last of HOLD cycles since load.
module hold_timer #(
  parameter int unsigned HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CntW'(HOLD - 1));

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks every input vector of a gate under test, lets it settle, then checks its
// output against TRUTH; reports error count and the first failing vector.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned             N_IN  = 1,
  parameter int unsigned             HOLD  = 4,
  parameter logic [(1<<N_IN)-1:0]    TRUTH = TruthNot
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            o,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  localparam logic [N_IN-1:0] LastVec = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            fvalid_q, fvalid_d;
  logic            timer_load, timer_en, timer_tc;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    fvec_d     = fvec_q;
    fvalid_d   = fvalid_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StHold;
          vec_d      = '0;
          err_d      = '0;
          fvec_d     = '0;
          fvalid_d   = 1'b0;
          timer_load = 1'b1;
        end
      end
      StHold: begin
        if (timer_tc) begin
          state_d = StCheck;
        end else begin
          timer_en = 1'b1;
        end
      end
      StCheck: begin
        // o is only trusted here, after the vector has had HOLD cycles to settle.
        if (o != TRUTH[vec_q]) begin
          err_d = err_q + (N_IN + 1)'(1);
          if (!fvalid_q) begin
            fvec_d   = vec_q;
            fvalid_d = 1'b1;
          end
        end
        if (vec_q == LastVec) begin
          state_d = StDone;
        end else begin
          state_d    = StHold;
          vec_d      = vec_q + N_IN'(1);
          timer_load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
    end
  end

  // Outputs decode registered state only; nothing from o or start reaches them directly.
  always_comb begin
    stim = '0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StHold, StCheck: begin
        stim = vec_q;
        busy = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass       = done && (err_q == '0);
  assign err_cnt    = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: a NOT-gate instance with injectable fault and a
// 2-input AND instance whose gate output is stuck at 0.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, start2 = 1'b0, fault = 1'b0, sel = 1'b0;
  logic       o1, stim1, busy1, done1, pass1, fvec1, fvalid1;
  logic [1:0] err1;
  logic       o2, busy2, done2, pass2, fvalid2;
  logic [1:0] stim2, fvec2;
  logic [2:0] err2;

  assign o1 = fault ? stim1 : ~stim1;
  assign o2 = 1'b0;

  gate_test_sequencer #(
    .N_IN  (1),
    .HOLD  (4),
    .TRUTH (TruthNot)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .o          (o1),
    .stim       (stim1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_cnt    (err1),
    .fail_vec   (fvec1),
    .fail_valid (fvalid1)
  );

  gate_test_sequencer #(
    .N_IN  (2),
    .HOLD  (2),
    .TRUTH (TruthAnd2)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .o          (o2),
    .stim       (stim2),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .err_cnt    (err2),
    .fail_vec   (fvec2),
    .fail_valid (fvalid2)
  );

  logic [1:0] obs_stim, obs_fvec;
  logic [2:0] obs_err;
  logic       obs_busy, obs_done, obs_pass, obs_fvalid;

  assign obs_stim   = sel ? stim2   : {1'b0, stim1};
  assign obs_fvec   = sel ? fvec2   : {1'b0, fvec1};
  assign obs_err    = sel ? err2    : {1'b0, err1};
  assign obs_busy   = sel ? busy2   : busy1;
  assign obs_done   = sel ? done2   : done1;
  assign obs_pass   = sel ? pass2   : pass1;
  assign obs_fvalid = sel ? fvalid2 : fvalid1;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_stim_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_start(input logic s, input logic v);
    if (s) start2 = v;
    else   start1 = v;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_stim"}, obs_stim, 0);
    check_eq({tag, "_busy"}, obs_busy, 0);
    check_eq({tag, "_done"}, obs_done, 0);
    check_eq({tag, "_pass"}, obs_pass, 0);
    check_eq({tag, "_err"}, obs_err, 0);
    check_eq({tag, "_fvalid"}, obs_fvalid, 0);
    check_eq({tag, "_fvec"}, obs_fvec, 0);
  endtask

  // One full run: expected stim per cycle is queued at start, popped each cycle,
  // and done must be up exactly nvec*(hold+1) edges after the start edge.
  task automatic run(input logic s, input logic flt, input int unsigned nvec,
                     input int unsigned hold, input bit noise, input int unsigned exp_err,
                     input int unsigned exp_fvec, input int unsigned exp_fvalid);
    int unsigned i;
    int unsigned e;
    sel   = s;
    fault = flt;
    @(negedge clk);
    drive_start(s, 1'b1);
    for (int unsigned v = 0; v < nvec; v++) begin
      for (int unsigned h = 0; h <= hold; h++) exp_stim_q.push_back(v);
    end
    @(negedge clk);
    drive_start(s, 1'b0);
    check_eq("start_err_cleared", obs_err, 0);
    check_eq("start_fvalid_cleared", obs_fvalid, 0);
    check_eq("start_done_low", obs_done, 0);
    i = 0;
    while (exp_stim_q.size() > 0) begin
      e = exp_stim_q.pop_front();
      check_eq("stim", obs_stim, e);
      check_eq("busy", obs_busy, 1);
      drive_start(s, noise && (i == 1 || i == hold));
      i++;
      @(negedge clk);
    end
    drive_start(s, 1'b0);
    check_eq("done", obs_done, 1);
    check_eq("done_busy", obs_busy, 0);
    check_eq("done_stim", obs_stim, 0);
    check_eq("err_cnt", obs_err, exp_err);
    check_eq("fail_valid", obs_fvalid, exp_fvalid);
    check_eq("fail_vec", obs_fvec, exp_fvec);
    check_eq("pass", obs_pass, (exp_err == 0) ? 1 : 0);
    @(negedge clk);
    check_eq("done_hold", obs_done, 1);
    check_eq("err_hold", obs_err, exp_err);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    sel = 1'b0;
    check_idle("reset1");
    sel = 1'b1;
    check_idle("reset2");
    rst = 1'b0;

    // Correct NOT, faulty buffer, restart from failing DONE with start noise mid-run.
    run(1'b0, 1'b0, 2, 4, 1'b0, 0, 0, 0);
    run(1'b0, 1'b1, 2, 4, 1'b0, 2, 0, 1);
    run(1'b0, 1'b0, 2, 4, 1'b1, 0, 0, 0);

    // AND2 with stuck-at-0 output: only vector 3 fails.
    run(1'b1, 1'b0, 4, 2, 1'b0, 1, 3, 1);

    // Reset in the 6th cycle of a faulty run aborts it.
    sel   = 1'b0;
    fault = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_stim", obs_stim, 1);
    check_eq("mid_err", obs_err, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b0;
    run(1'b0, 1'b0, 2, 4, 1'b0, 0, 0, 0);

    // start and rst together: reset wins, no run begins.
    @(negedge clk);
    rst    = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    start1 = 1'b0;
    check_idle("rst_vs_start");
    repeat (3) @(negedge clk);
    check_eq("no_run_busy", obs_busy, 0);
    check_eq("no_run_done", obs_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
